transpose_writeback_buffer: RTL and testbench

Column-to-row packer for the write-back path, the inverse of the read-side transpose buffer. It accepts one stencil column per cycle (STENCIL_HEIGHT pixels) from the compute datapath. It collects FETCH_WIDTH columns in one bank of a ping-pong buffer, then emits STENCIL_HEIGHT memory words of FETCH_WIDTH pixels each toward the memory write port. A per-lane mask on each word marks which lanes hold real data, so a partial block written by a flush is handled correctly.

---
 rtl/transpose_writeback_buffer.sv | 133 +++++++++++++
 tb/tb_transpose_writeback_buffer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_writeback_buffer.sv
// ---------------------------------------------------------------------------
// transpose_writeback_buffer
//   Column-to-row packer for the write-back path. Columns of STENCIL_HEIGHT
//   pixels arrive one per cycle and are collected into one bank of a
//   ping-pong buffer. Once a bank holds FETCH_WIDTH columns (or a flush
//   closes it early) it is drained as STENCIL_HEIGHT memory words of
//   FETCH_WIDTH pixels each, with a lane mask marking the populated columns.
//
// Ports
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   col_pixels  : input column, pixel r at [r*DATA_WIDTH +: DATA_WIDTH]
//   col_valid   : column valid
//   col_ready   : column accepted when col_valid & col_ready
//   flush       : single-cycle pulse, closes a partially filled bank
//   mem_data    : output word, lane c = column c of row mem_row
//   mem_mask    : lane-valid mask of the output word
//   mem_row     : row index of the output word
//   mem_valid   : output word valid
//   mem_ready   : memory side takes the word when mem_valid & mem_ready
// ---------------------------------------------------------------------------
module transpose_writeback_buffer #(
  parameter  int STENCIL_HEIGHT = 5,
  parameter  int FETCH_WIDTH    = 4,
  parameter  int DATA_WIDTH     = 8,
  localparam int RW = (STENCIL_HEIGHT > 1) ? $clog2(STENCIL_HEIGHT) : 1,
  localparam int WW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
  localparam int CW = $clog2(FETCH_WIDTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [STENCIL_HEIGHT*DATA_WIDTH-1:0] col_pixels,
  input  logic                                 col_valid,
  output logic                                 col_ready,
  input  logic                                 flush,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0]    mem_data,
  output logic [FETCH_WIDTH-1:0]               mem_mask,
  output logic [RW-1:0]                        mem_row,
  output logic                                 mem_valid,
  input  logic                                 mem_ready
);

  // Ping-pong storage: [bank][row][column]
  logic [DATA_WIDTH-1:0] r_bank [0:1][0:STENCIL_HEIGHT-1][0:FETCH_WIDTH-1];
  logic [1:0]            r_full;
  logic [CW-1:0]         r_cols [0:1];
  logic                  r_fill_sel;
  logic [WW-1:0]         r_wcol;
  logic                  r_drain_sel;
  logic [RW-1:0]         r_rrow;

  logic                  w_acc;
  logic                  w_last_col;
  logic                  w_close;
  logic [CW-1:0]         w_close_cols;
  logic                  w_take;
  logic                  w_last_row;
  logic [FETCH_WIDTH:0]  w_mask_ext;

  // Ready depends on registered state only: a bank released this cycle is
  // only offered to the fill side from the next cycle on.
  assign col_ready  = !rst && !r_full[r_fill_sel];
  assign w_acc      = col_valid && col_ready;
  assign w_last_col = w_acc && (r_wcol == WW'(FETCH_WIDTH - 1));

  // A flush on an empty bank (no accept, wcol == 0) is ignored.
  assign w_close = w_last_col || (flush && (w_acc || (r_wcol != '0)));

  always_comb begin
    w_close_cols = CW'(r_wcol);
    if (w_last_col)
      w_close_cols = CW'(FETCH_WIDTH);
    else if (w_acc)
      w_close_cols = CW'(r_wcol) + CW'(1);
  end

  assign mem_valid  = r_full[r_drain_sel];
  assign mem_row    = r_rrow;
  assign w_take     = mem_valid && mem_ready;
  assign w_last_row = (r_rrow == RW'(STENCIL_HEIGHT - 1));

  assign w_mask_ext = ((FETCH_WIDTH+1)'(1) << r_cols[r_drain_sel]) - (FETCH_WIDTH+1)'(1);
  assign mem_mask   = mem_valid ? w_mask_ext[FETCH_WIDTH-1:0] : '0;

  // Lanes beyond the bank's column count read as zero so a partial block
  // never exposes stale pixels from an earlier block.
  for (genvar c = 0; c < FETCH_WIDTH; c++) begin : g_lane
    assign mem_data[c*DATA_WIDTH +: DATA_WIDTH] =
      (mem_valid && (CW'(c) < r_cols[r_drain_sel])) ? r_bank[r_drain_sel][r_rrow][c] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < STENCIL_HEIGHT; r++)
          for (int c = 0; c < FETCH_WIDTH; c++)
            r_bank[b][r][c] <= '0;
        r_cols[b] <= '0;
      end
      r_full      <= '0;
      r_fill_sel  <= 1'b0;
      r_wcol      <= '0;
      r_drain_sel <= 1'b0;
      r_rrow      <= '0;
    end else begin
      // Fill side
      if (w_acc)
        for (int r = 0; r < STENCIL_HEIGHT; r++)
          r_bank[r_fill_sel][r][r_wcol] <= col_pixels[r*DATA_WIDTH +: DATA_WIDTH];

      if (w_close) begin
        r_full[r_fill_sel] <= 1'b1;
        r_cols[r_fill_sel] <= w_close_cols;
        r_fill_sel         <= ~r_fill_sel;
        r_wcol             <= '0;
      end else if (w_acc) begin
        r_wcol <= r_wcol + WW'(1);
      end

      // Drain side. A closing fill bank is never full, so it never equals
      // the bank being released here; both flag updates apply independently.
      if (w_take) begin
        if (w_last_row) begin
          r_full[r_drain_sel] <= 1'b0;
          r_drain_sel         <= ~r_drain_sel;
          r_rrow              <= '0;
        end else begin
          r_rrow <= r_rrow + RW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_transpose_writeback_buffer.sv
module tb_transpose_writeback_buffer;
  localparam int SH = 5;
  localparam int FW = 4;
  localparam int DW = 8;

  logic             clk;
  logic             rst;
  logic [SH*DW-1:0] col_pixels;
  logic             col_valid;
  logic             col_ready;
  logic             flush;
  logic [FW*DW-1:0] mem_data;
  logic [FW-1:0]    mem_mask;
  logic [2:0]       mem_row;
  logic             mem_valid;
  logic             mem_ready;

  transpose_writeback_buffer #(.STENCIL_HEIGHT(SH), .FETCH_WIDTH(FW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .col_pixels(col_pixels), .col_valid(col_valid),
    .col_ready(col_ready), .flush(flush), .mem_data(mem_data), .mem_mask(mem_mask),
    .mem_row(mem_row), .mem_valid(mem_valid), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [FW*DW-1:0] d;
    logic [FW-1:0]    m;
    logic [2:0]       row;
  } word_t;

  word_t      q[$];
  logic [7:0] m_blk [SH][FW];
  int         m_wcol;
  bit         m_acc;
  int         nchk;
  int         nerr;

  function automatic logic [SH*DW-1:0] colpix(input int k);
    logic [SH*DW-1:0] p;
    for (int r = 0; r < SH; r++) p[r*DW +: DW] = 8'(16*r + k);
    return p;
  endfunction

  // One cycle: drive inputs at negedge, compare outputs against the
  // scoreboard, then advance the reference model for the coming posedge.
  task automatic drive_cycle(input bit v, input logic [SH*DW-1:0] pix, input bit fl, input bit rdy);
    bit    er, ev, acc, take, close;
    int    cols;
    word_t w;
    @(negedge clk);
    col_valid = v; col_pixels = pix; flush = fl; mem_ready = rdy;
    er = !rst && (((q.size() + SH - 1) / SH) < 2);
    ev = !rst && (q.size() != 0);
    nchk++;
    if (col_ready !== er) begin
      nerr++; $display("FAIL col_ready: got %b expected %b at %0t", col_ready, er, $time);
    end
    nchk++;
    if (mem_valid !== ev) begin
      nerr++; $display("FAIL mem_valid: got %b expected %b at %0t", mem_valid, ev, $time);
    end
    nchk++;
    if (ev) begin
      if (mem_data !== q[0].d || mem_mask !== q[0].m || mem_row !== q[0].row) begin
        nerr++;
        $display("FAIL word: got d=%h m=%b row=%0d expected d=%h m=%b row=%0d at %0t",
                 mem_data, mem_mask, mem_row, q[0].d, q[0].m, q[0].row, $time);
      end
    end else if (mem_mask !== '0) begin
      nerr++; $display("FAIL idle_mask: got %b expected 0 at %0t", mem_mask, $time);
    end
    acc = v && er;
    m_acc = acc;
    take = ev && rdy;
    if (take) void'(q.pop_front());
    close = 0; cols = 0;
    if (acc) for (int r = 0; r < SH; r++) m_blk[r][m_wcol] = pix[r*DW +: DW];
    if (acc && m_wcol == FW-1) begin
      close = 1; cols = FW;
    end else if (fl && !rst && (acc || m_wcol > 0)) begin
      close = 1; cols = acc ? m_wcol + 1 : m_wcol;
    end
    if (close) begin
      for (int r = 0; r < SH; r++) begin
        w.d = '0;
        for (int c = 0; c < FW; c++) if (c < cols) w.d[c*DW +: DW] = m_blk[r][c];
        w.m = FW'((1 << cols) - 1);
        w.row = 3'(r);
        q.push_back(w);
      end
      m_wcol = 0;
    end else if (acc) begin
      m_wcol++;
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive_cycle(0, '0, 0, rdy);
  endtask

  task automatic drain_all;
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      drive_cycle(0, '0, 0, 1);
      n++;
    end
    drive_cycle(0, '0, 0, 1);
    nchk++;
    if (q.size() != 0) begin
      nerr++; $display("FAIL drain_timeout: %0d words left, expected 0", q.size());
    end
  endtask

  task automatic test_reset;
    rst = 1; col_valid = 0; flush = 0; mem_ready = 0; col_pixels = '0;
    q.delete(); m_wcol = 0;
    repeat (3) @(negedge clk);
    nchk++;
    if (col_ready !== 0 || mem_valid !== 0 || mem_mask !== 0 || mem_row !== 0 || mem_data !== 0) begin
      nerr++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b m=%b row=%0d d=%h expected all 0",
               col_ready, mem_valid, mem_mask, mem_row, mem_data);
    end
    rst = 0;
    idle(2, 0);
  endtask

  task automatic test_single_block;
    for (int k = 0; k < FW; k++) drive_cycle(1, colpix(k), 0, 1);
    drive_cycle(0, '0, 0, 1);
    nchk++;
    if (mem_valid !== 1 || mem_data !== 32'h03020100 || mem_mask !== 4'hF || mem_row !== 0) begin
      nerr++;
      $display("FAIL single_row0: got v=%b d=%h m=%b row=%0d expected v=1 d=03020100 m=1111 row=0",
               mem_valid, mem_data, mem_mask, mem_row);
    end
    idle(3, 1);
    drive_cycle(0, '0, 0, 1);
    nchk++;
    if (mem_valid !== 1 || mem_data !== 32'h43424140 || mem_row !== 4) begin
      nerr++;
      $display("FAIL single_row4: got v=%b d=%h row=%0d expected v=1 d=43424140 row=4",
               mem_valid, mem_data, mem_row);
    end
    drive_cycle(0, '0, 0, 1);
    nchk++;
    if (mem_valid !== 0) begin
      nerr++; $display("FAIL single_end: mem_valid got %b expected 0", mem_valid);
    end
  endtask

  task automatic test_backpressure;
    int nacc, t;
    bit got;
    nacc = 0;
    for (int i = 0; i < 9; i++) begin
      drive_cycle(1, colpix(nacc), 0, 0);
      if (m_acc) nacc++;
    end
    nchk++;
    if (nacc != 8) begin
      nerr++; $display("FAIL bp_accepts: got %0d expected 8", nacc);
    end
    got = 0; t = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      drive_cycle(1, colpix(8), 0, 1);
      if (m_acc) begin got = 1; t = i; end
    end
    nchk++;
    if (!got || t != 6) begin
      nerr++; $display("FAIL bp_ninth_accept: got cycle %0d expected 6", t);
    end
    // Close the bank holding the 9th column so the bench ends clean.
    drive_cycle(0, '0, 1, 1);
    drain_all();
  endtask

  task automatic test_flush_partial;
    drive_cycle(1, colpix(0), 0, 1);
    drive_cycle(1, colpix(1), 0, 1);
    drive_cycle(0, '0, 1, 1);
    idle(2, 1);
    drive_cycle(0, '0, 0, 1);
    nchk++;
    if (mem_valid !== 1 || mem_data !== 32'h00002120 || mem_mask !== 4'b0011 || mem_row !== 2) begin
      nerr++;
      $display("FAIL flush_row2: got v=%b d=%h m=%b row=%0d expected v=1 d=00002120 m=0011 row=2",
               mem_valid, mem_data, mem_mask, mem_row);
    end
    drain_all();
  endtask

  task automatic test_flush_corners;
    drive_cycle(1, colpix(0), 0, 0);
    drive_cycle(1, colpix(1), 0, 0);
    drive_cycle(1, colpix(2), 1, 0);
    drive_cycle(0, '0, 0, 0);
    nchk++;
    if (mem_valid !== 1 || mem_mask !== 4'b0111 || mem_data !== 32'h00020100) begin
      nerr++;
      $display("FAIL flush_same_cycle: got v=%b m=%b d=%h expected v=1 m=0111 d=00020100",
               mem_valid, mem_mask, mem_data);
    end
    drain_all();
    drive_cycle(0, '0, 1, 1);
    drive_cycle(0, '0, 0, 1);
    nchk++;
    if (mem_valid !== 0) begin
      nerr++; $display("FAIL flush_empty: mem_valid got %b expected 0", mem_valid);
    end
    // A full block afterwards must still close at 4 columns.
    for (int k = 0; k < FW; k++) drive_cycle(1, colpix(k + 4), 0, 1);
    drive_cycle(0, '0, 0, 1);
    nchk++;
    if (mem_mask !== 4'hF || mem_data !== 32'h07060504) begin
      nerr++;
      $display("FAIL flush_empty_after: got m=%b d=%h expected m=1111 d=07060504", mem_mask, mem_data);
    end
    drain_all();
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < FW; k++) drive_cycle(1, colpix(k + 8), 0, 0);
    drive_cycle(1, colpix(4), 0, 1);
    drive_cycle(1, colpix(5), 0, 1);
    col_valid = 0; flush = 0; mem_ready = 1;
    @(posedge clk);
    #2 rst = 1;
    #1;
    nchk++;
    if (mem_valid !== 0 || col_ready !== 0 || mem_mask !== 0 || mem_row !== 0 || mem_data !== 0) begin
      nerr++;
      $display("FAIL reset_mid: got vld=%b rdy=%b m=%b row=%0d d=%h expected all 0",
               mem_valid, col_ready, mem_mask, mem_row, mem_data);
    end
    q.delete(); m_wcol = 0;
    idle(2, 1);
    rst = 0;
    drive_cycle(1, colpix(0), 0, 1);
    drive_cycle(1, colpix(1), 0, 1);
    drive_cycle(0, '0, 1, 1);
    drive_cycle(0, '0, 0, 1);
    nchk++;
    if (mem_valid !== 1 || mem_row !== 0 || mem_data !== 32'h00000100 || mem_mask !== 4'b0011) begin
      nerr++;
      $display("FAIL reset_fresh: got v=%b row=%0d d=%h m=%b expected v=1 row=0 d=00000100 m=0011",
               mem_valid, mem_row, mem_data, mem_mask);
    end
    drain_all();
  endtask

  task automatic test_random;
    logic [63:0]      rnd;
    logic [SH*DW-1:0] pix;
    for (int i = 0; i < 500; i++) begin
      rnd = {$urandom, $urandom};
      pix = rnd[SH*DW-1:0];
      drive_cycle($urandom_range(0, 9) < 7, pix, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 6);
    end
    drive_cycle(0, '0, 1, 1);
    drain_all();
  endtask

  initial begin
    nchk = 0; nerr = 0;
    test_reset();
    test_single_block();
    test_backpressure();
    test_flush_partial();
    test_flush_corners();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
